// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state type, default sizes and half-bit constant for the UART receiver
package uart_rx_pkg;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  function automatic int half_bit(input int oversample);
    return oversample / 2 - 1;
  endfunction

  localparam int HALF_BIT = half_bit(OVERSAMPLE_DEF);
endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte result bus; parity_err exists only with UART_RX_PARITY_EN
interface uart_rx_if #(parameter int DATA_BITS = uart_rx_pkg::DATA_BITS_DEF);
  logic [DATA_BITS-1:0] d_out;
  logic                 rx_done;
  logic                 frame_err;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;

  modport master (output d_out, rx_done, frame_err, parity_err);
  modport slave  (input  d_out, rx_done, frame_err, parity_err);
`else
  modport master (output d_out, rx_done, frame_err);
  modport slave  (input  d_out, rx_done, frame_err);
`endif
endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop rx synchronizer (resets high) with registered falling-edge detect
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_sync,
  output logic fall
);
  logic meta;

  // fall lines up with the cycle in which rx_sync first shows the low level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta    <= 1'b1;
      rx_sync <= 1'b1;
      fall    <= 1'b0;
    end else begin
      meta    <= rx;
      rx_sync <= meta;
      fall    <= rx_sync & ~meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampled 8-N-1 UART receiver; UART_RX_PARITY_EN adds an even-parity bit and parity_err
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      b_tick,
  input  logic      rx,
  uart_rx_if.master bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_HALF = TW'(half_bit(OVERSAMPLE));
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  rx_state_t            state, state_n;
  logic [TW-1:0]        tick, tick_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] d_out_q, d_out_n;
  logic                 done_q, done_n;
  logic                 ferr_q, ferr_n;
  logic                 rx_sync, fall;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, par_n;
  logic                 perr_q, perr_n;
`endif

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .rx_sync (rx_sync),
    .fall    (fall)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      d_out_q <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      tick    <= tick_n;
      bit_cnt <= bit_n;
      shift   <= shift_n;
      d_out_q <= d_out_n;
      done_q  <= done_n;
      ferr_q  <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par_bit <= par_n;
      perr_q  <= perr_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    tick_n  = tick;
    bit_n   = bit_cnt;
    shift_n = shift;
    d_out_n = d_out_q;
    done_n  = 1'b0;
    ferr_n  = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_n   = par_bit;
    perr_n  = perr_q;
`endif
    unique case (state)
      IDLE: begin
        tick_n = '0;
        bit_n  = '0;
        if (fall) state_n = START;
      end
      START: if (b_tick) begin
        // a start bit that is high again at its midpoint is a glitch
        if (tick == TICK_HALF) begin
          tick_n  = '0;
          state_n = rx_sync ? IDLE : DATA;
        end else begin
          tick_n = tick + 1'b1;
        end
      end
      DATA: if (b_tick) begin
        if (tick == TICK_LAST) begin
          tick_n  = '0;
          shift_n = {rx_sync, shift[DATA_BITS-1:1]};
          if (bit_cnt == BIT_LAST) begin
            bit_n = '0;
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end else begin
          tick_n = tick + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (b_tick) begin
        if (tick == TICK_LAST) begin
          tick_n  = '0;
          par_n   = rx_sync;
          state_n = STOP;
        end else begin
          tick_n = tick + 1'b1;
        end
      end
`endif
      STOP: if (b_tick) begin
        if (tick == TICK_LAST) begin
          tick_n  = '0;
          d_out_n = shift;
          ferr_n  = ~rx_sync;
          done_n  = 1'b1;
`ifdef UART_RX_PARITY_EN
          perr_n  = (^shift) ^ par_bit;
`endif
          state_n = IDLE;
        end else begin
          tick_n = tick + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.d_out     = d_out_q;
  assign bus.rx_done   = done_q;
  assign bus.frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx with a frame-level expectation queue; honours UART_RX_PARITY_EN
module tb_uart_rx;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic b_tick = 1'b0;
  logic rx     = 1'b1;
  int   tick_div = 4;
  int   tick_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  logic [7:0] held_d  = 8'h00;
  logic       held_fe = 1'b0;
  logic       held_pe = 1'b0;
  logic       prev_done = 1'b0;
  logic       in_stop = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;
  int         done_cnt = 0;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .b_tick (b_tick),
    .rx     (rx),
    .bus    (bus)
  );

  always #10 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      tick_cnt++;
      if (tick_cnt >= tick_div) begin
        tick_cnt = 0;
        b_tick   = 1'b1;
      end else begin
        b_tick = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // outputs must always equal the last completed frame of the model
  always @(negedge clk) begin
    if (reset) begin
      held_d    = 8'h00;
      held_fe   = 1'b0;
      held_pe   = 1'b0;
      prev_done = 1'b0;
      check("reset_d_out", bus.d_out, 0);
      check("reset_rx_done", bus.rx_done, 0);
      check("reset_frame_err", bus.frame_err, 0);
    end else begin
      if (bus.rx_done) begin
        done_cnt++;
        check("done_single_cycle", prev_done, 0);
        check("done_in_stop_bit", in_stop, 1);
        check("done_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e       = exp_q.pop_front();
          held_d  = e.data;
          held_fe = e.ferr;
          held_pe = e.perr;
        end
      end
      check("d_out", bus.d_out, held_d);
      check("frame_err", bus.frame_err, held_fe);
`ifdef UART_RX_PARITY_EN
      check("parity_err", bus.parity_err, held_pe);
`endif
      prev_done = bus.rx_done;
    end
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!b_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic pbit, input logic stop, input logic expect_done);
    exp_t x;
    if (expect_done) begin
      x.data = data;
      x.ferr = ~stop;
      x.perr = (^data) ^ pbit;
      exp_q.push_back(x);
    end
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(pbit);
`endif
    in_stop = 1'b1;
    send_bit(stop);
    in_stop = 1'b0;
  endtask

  task automatic good_frame(input logic [7:0] data);
    send_frame(data, ^data, 1'b1, 1'b1);
  endtask

  task automatic idle(input int bits);
    rx = 1'b1;
    wait_ticks(16 * bits);
  endtask

  task automatic pin(input string name, input logic [7:0] d, input logic fe, input int dones);
    check({name, "_d_out"}, bus.d_out, d);
    check({name, "_frame_err"}, bus.frame_err, fe);
    check({name, "_done_count"}, done_cnt, dones);
    check({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    repeat (4) @(negedge clk);
    check("por_d_out", bus.d_out, 8'h00);
    check("por_frame_err", bus.frame_err, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(2);

    good_frame(8'h55);
    idle(1);
    pin("basic", 8'h55, 1'b0, 1);

    send_frame(8'hA3, ^8'hA3, 1'b0, 1'b1);
    idle(1);
    pin("ferr", 8'hA3, 1'b1, 2);
    good_frame(8'h01);
    idle(1);
    pin("ferr_clear", 8'h01, 1'b0, 3);

    rx = 1'b0;
    wait_ticks(4);
    idle(3);
    pin("glitch", 8'h01, 1'b0, 3);

    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_d_out", bus.d_out, 8'h00);
    check("midreset_rx_done", bus.rx_done, 0);
    check("midreset_frame_err", bus.frame_err, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(3);
    pin("after_reset_idle", 8'h00, 1'b0, 3);
    good_frame(8'h3C);
    idle(1);
    pin("after_reset", 8'h3C, 1'b0, 4);

    good_frame(8'h00);
    good_frame(8'hFF);
    idle(1);
    pin("back_to_back", 8'hFF, 1'b0, 6);

    exp_q.push_back('{data: 8'h00, ferr: 1'b1, perr: 1'b0});
    rx = 1'b0;
    wait_ticks(16 * (FRAME_BITS - 1));
    in_stop = 1'b1;
    wait_ticks(16);
    in_stop = 1'b0;
    wait_ticks(16 * FRAME_BITS);
    idle(2);
    pin("break", 8'h00, 1'b1, 7);

    tick_div = 1;
    idle(1);
    good_frame(8'h96);
    idle(1);
    pin("fast_tick", 8'h96, 1'b0, 8);
    tick_div = 4;
    idle(1);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    idle(1);
    check("parity_ok", bus.parity_err, 0);
    send_frame(8'h07, 1'b0, 1'b1, 1'b1);
    idle(1);
    check("parity_bad", bus.parity_err, 1);
    pin("parity", 8'h07, 1'b0, 10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that sits directly downstream of the UART transmitter on the serial line. It recovers bytes from an asynchronous 8-N-1 stream using the shared 16× oversampling baud tick from the baud generator. It reports each byte with a single-cycle done strobe and a framing-error flag for the AHB UART register layer.

## Interface
- `OVERSAMPLE`, default 16: `b_tick` pulses per bit period.
- `DATA_BITS`, default 8: data bits per frame, sent LSB first.
- `clk` input, 1 bit: system clock (50 MHz nominal).
- `reset` input, 1 bit: asynchronous, active-high reset.
- `b_tick` input, 1 bit: single-cycle pulse at OVERSAMPLE × baud rate, from the baud generator.
- `rx` input, 1 bit: asynchronous serial line, idle high.
- `d_out` output, DATA_BITS: last received byte, held until the next `rx_done`.
- `rx_done` output, 1 bit: one-`clk` pulse when a frame completes.
- `frame_err` output, 1 bit: stop bit of the last frame sampled low; held until the next `rx_done`.
- `parity_err` output, 1 bit: present only with `UART_RX_PARITY_EN`.

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1 so reset cannot produce a false start.
- A 4-bit tick counter advances only on `b_tick`. A bit counter runs 0..DATA_BITS-1. A shift register shifts right, so the first bit received ends up in bit 0.
- **IDLE**
  - Tick counter is held at 0.
  - A falling edge on the synchronized `rx` (previous 1, current 0) moves to START.
  - Edge detection means a sustained low (break) does not retrigger.
- **START**
  - At the tick where the count reaches OVERSAMPLE/2-1 (7), sample `rx`.
  - If `rx` is still low: clear the tick counter and go to DATA.
  - If `rx` is high: treat it as a glitch and return to IDLE with no outputs changed.
- **DATA**
  - At each tick where the count reaches OVERSAMPLE-1 (15), shift the synchronized `rx` in and clear the tick counter.
  - After bit DATA_BITS-1, go to PARITY (if enabled) or STOP.
- **PARITY** (only with `UART_RX_PARITY_EN`): sample at count 15 using the same rule as DATA, then go to STOP.
- **STOP**
  - At count 15, sample `rx`.
  - Load `d_out` from the shift register.
  - Set `frame_err` to the inverse of the sampled stop bit.
  - Pulse `rx_done`.
  - Return to IDLE.
- A framing error still delivers the byte and `rx_done`. A break therefore yields `d_out`=0x00 with `frame_err`=1.

## Timing
- Reset values: `d_out`=0, `rx_done`=0, `frame_err`=0, `parity_err`=0, FSM in IDLE, all counters 0, shift register 0.
- Reset asserted mid-frame returns to IDLE immediately. The partial byte is discarded and no `rx_done` is produced.
- The synchronizer adds 2 `clk` of latency from the `rx` pin.
- `rx_done`, `d_out` and `frame_err` are registered. They update in the `clk` cycle after the `b_tick` that samples the middle of the stop bit.
- `rx_done` is high for exactly one `clk`, regardless of `b_tick` spacing.
- Back-to-back frames are supported: a start edge arriving in the `clk` right after STOP completes is accepted.
- Each bit is sampled at its midpoint, 16 ticks apart. The receiver tolerates about ±3% baud mismatch.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Adds the PARITY state, which expects an even-parity bit between the last data bit and the stop bit.
  - `parity_err` is set to (XOR of data bits) XOR (received parity bit).
  - `parity_err` updates together with `rx_done`.
- `UART_RX_PARITY_EN` not defined:
  - Frames are 8-N-1.
  - The `parity_err` port and the PARITY state are absent.

## Structure
- Shared package holds:
  - the `rx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - `OVERSAMPLE` and `DATA_BITS` defaults;
  - a `HALF_BIT` = OVERSAMPLE/2-1 constant.
- Sub-module `uart_rx_sync`: 2-flop synchronizer with a reset value of 1, plus a registered falling-edge detect output.

## Test plan
- **Basic frame:** 19200 baud, byte 0x55, stop bit 1 → exactly one `rx_done` pulse; `d_out`=0x55; `frame_err`=0.
- **Framing error:** byte 0xA3 with stop bit 0 → `rx_done` pulses; `d_out`=0xA3; `frame_err`=1. The next good frame 0x01 clears `frame_err` to 0.
- **Start-bit glitch:** `rx` low for 4 `b_tick`s, then high → FSM returns to IDLE; no `rx_done`; `d_out` unchanged.
- **Reset mid-frame:** assert `reset` after 3 data bits of 0xFF → all outputs 0. The following frame 0x3C is received correctly.
- **Back-to-back / break:**
  - Frames 0x00 then 0xFF with no idle gap → two `rx_done` pulses with matching `d_out` values.
  - A 2-frame-long low → one `rx_done` with `d_out`=0x00 and `frame_err`=1, and no retrigger.
- **Parity (`UART_RX_PARITY_EN`):**
  - 0x07 with parity bit 1 → `parity_err`=0.
  - 0x07 with parity bit 0 → `parity_err`=1.
